core_sequencer: RTL and testbench

Fetch/decode/execute sequencer for the OpenCore 8-bit core. It drives the program counter into the 16-entry instruction ROM. It runs a register-preload phase (ROM words 0–7 written into R0–R7), then executes instructions from words 8–15. It drives the register-file read/write ports and the external ALU opcode, and stops on HALT or end of ROM.

---
 rtl/opencore_pkg.sv | 42 ++++
 rtl/core_sequencer.sv | 150 +++++++++++++++
 tb/tb_core_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/opencore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opencore_pkg
// Description : Shared types and defaults for the OpenCore 8-bit core:
//               opcode encoding, instruction field layout, sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package opencore_pkg;

    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_ADD  = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    // Instruction word layout: [7:6] opcode, [5:3] rd, [2:0] rs.
    typedef struct packed {
        opcode_e    op;
        logic [2:0] rd;
        logic [2:0] rs;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Four-bit counter increment that sticks at its maximum.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Fetch/decode/execute sequencer. Preloads R0..R7 from ROM
//               words 0..7, then runs two-cycle FETCH/EXEC instructions from
//               the remaining ROM words until HALT or the last address.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import opencore_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [2:0]        rf_raddr_a,
    output logic [2:0]        rf_raddr_b,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              done,
    output logic [3:0]        retired
);

    localparam logic [2:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [2:0] c_ST_LOAD  = ST_LOAD;
    localparam logic [2:0] c_ST_FETCH = ST_FETCH;
    localparam logic [2:0] c_ST_EXEC  = ST_EXEC;
    localparam logic [2:0] c_ST_DONE  = ST_DONE;

    localparam logic [ADDR_W-1:0] c_LAST_LOAD = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    instr_t            r_ir;
    logic [3:0]        r_retired;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    instr_t            w_ir_nxt;
    logic [3:0]        w_retired_nxt;
    logic              w_is_halt;
    logic              w_we;

    assign w_is_halt = (r_ir.op == OP_HALT);

    // Next-state, pc, ir and retired-count logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_retired_nxt = r_retired;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (start) begin
                    w_pc_nxt      = '0;
                    w_retired_nxt = 4'd0;
                    w_state_nxt   = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_pc_nxt = r_pc + 1'b1;
                if (r_pc == c_LAST_LOAD) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_ir_nxt    = instr_t'(rom_data[7:0]);
                w_state_nxt = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                if (w_is_halt) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_retired_nxt = sat_inc4(r_retired);
                    if (r_pc == c_LAST_ADDR) begin
                        // Never wrap: the last ROM word ends the run.
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_pc_nxt    = r_pc + 1'b1;
                        w_state_nxt = c_ST_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State registers; hold freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= 4'd0;
        end else if (!hold) begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    // Register-file, ALU and status outputs decoded from the current state.
    always_comb begin
        rf_raddr_a = 3'd0;
        rf_raddr_b = 3'd0;
        alu_op     = 2'd0;
        rf_waddr   = 3'd0;
        rf_wdata   = '0;
        w_we       = 1'b0;
        if (r_state == c_ST_EXEC) begin
            rf_raddr_a = r_ir.rd;
            rf_raddr_b = r_ir.rs;
            alu_op     = r_ir.op;
        end
        if (!hold) begin
            if (r_state == c_ST_LOAD) begin
                w_we     = 1'b1;
                rf_waddr = r_pc[2:0];
                rf_wdata = rom_data;
            end else if (r_state == c_ST_EXEC && !w_is_halt) begin
                w_we     = 1'b1;
                rf_waddr = r_ir.rd;
                rf_wdata = alu_result;
            end
        end
    end

    assign rf_we    = w_we;
    assign rom_addr = r_pc;
    assign busy     = (r_state == c_ST_LOAD) || (r_state == c_ST_FETCH) ||
                      (r_state == c_ST_EXEC);
    assign done     = (r_state == c_ST_DONE);
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Scoreboard bench for core_sequencer with ROM, register-file
//               and ALU models. Expected register writes (cycle, address,
//               data) are queued by the stimulus and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;
    import opencore_pkg::*;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [2:0] rf_raddr_a;
    logic [2:0] rf_raddr_b;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic       done;
    logic [3:0] retired;

    logic [7:0] rom  [16];
    logic [7:0] regs [8];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         edge_n;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t q[$];
    wr_t mon_e;

    core_sequencer #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold       (hold),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: ROM, register file and ALU beside the sequencer.
    assign rom_data = rom[rom_addr];

    always @(posedge clk) begin
        if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    always_comb begin
        case (alu_op)
            2'b00:   alu_result = regs[rf_raddr_a] & regs[rf_raddr_b];
            2'b01:   alu_result = regs[rf_raddr_a] | regs[rf_raddr_b];
            2'b10:   alu_result = regs[rf_raddr_a] + regs[rf_raddr_b];
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must match the next queued one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual waddr=%0d wdata=%0h required none (cycle %0d)",
                         rf_waddr, rf_wdata, cyc);
            end else begin
                mon_e = q.pop_front();
                check("wr_edge", cyc + 1, mon_e.edge_n);
                check("wr_addr", {29'd0, rf_waddr}, {29'd0, mon_e.addr});
                check("wr_data", {24'd0, rf_wdata}, {24'd0, mon_e.data});
            end
        end else begin
            check("idle_wport", {21'd0, rf_waddr, rf_wdata}, 32'd0);
        end
    end

    task automatic wait_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(output int k);
        start = 1'b1;
        k = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_wr(input int e, input logic [2:0] a, input logic [7:0] d);
        wr_t w;
        w.edge_n = e;
        w.addr   = a;
        w.data   = d;
        q.push_back(w);
    endtask

    task automatic push_preload(input int k);
        for (int i = 0; i < 8; i++) expect_wr(k + 1 + i, 3'(i), rom[i]);
    endtask

    task automatic load_preload_words();
        rom[0] = 8'hfe; rom[1] = 8'hf1; rom[2] = 8'h00; rom[3] = 8'hff;
        rom[4] = 8'haa; rom[5] = 8'hbb; rom[6] = 8'hcc; rom[7] = 8'h01;
    endtask

    // Program A: AND R3,R7 then HALT.
    task automatic load_rom_a();
        load_preload_words();
        for (int i = 8; i < 16; i++) rom[i] = 8'h00;
        rom[8] = 8'h1f;
        rom[9] = 8'hc0;
    endtask

    // Program B: eight instructions, no HALT.
    task automatic load_rom_b();
        load_preload_words();
        rom[8]  = 8'h81;  // ADD R0,R1 : fe+f1 -> ef
        rom[9]  = 8'h54;  // OR  R2,R4 : 00|aa -> aa
        rom[10] = 8'h2e;  // AND R5,R6 : bb&cc -> 88
        rom[11] = 8'hbf;  // ADD R7,R7 : 01+01 -> 02
        rom[12] = 8'h9f;  // ADD R3,R7 : ff+02 -> 01
        rom[13] = 8'h70;  // OR  R6,R0 : cc|ef -> ef
        rom[14] = 8'h8a;  // ADD R1,R2 : f1+aa -> 9b
        rom[15] = 8'h20;  // AND R4,R0 : aa&ef -> aa
    endtask

    logic [2:0] b_addr [8] = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd3, 3'd6, 3'd1, 3'd4};
    logic [7:0] b_data [8] = '{8'hef, 8'haa, 8'h88, 8'h02, 8'h01, 8'hef, 8'h9b, 8'haa};

    initial begin
        int k;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_retired", {28'd0, retired}, 32'd0);
        rst = 1'b0;
        wait_edge(cyc + 2);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Program A: preload, one AND, HALT
        load_rom_a();
        launch(k);
        push_preload(k);
        expect_wr(k + 10, 3'd3, 8'h01);
        wait_edge(k + 4);
        check("busy_preload", {31'd0, busy}, 32'd1);
        wait_edge(k + 10);
        check("a_alu_op_zero_fetch", {30'd0, alu_op}, 32'd0);
        wait_edge(k + 11);
        check("a_done_early", {31'd0, done}, 32'd0);
        wait_edge(k + 12);
        check("a_done", {31'd0, done}, 32'd1);
        check("a_retired", {28'd0, retired}, 32'd1);
        check("a_rom_addr", {28'd0, rom_addr}, 32'd9);
        check("a_busy", {31'd0, busy}, 32'd0);

        // Program B: restart from DONE, ADD wrap, full ROM
        wait_edge(k + 14);
        load_rom_b();
        launch(k);
        check("b_retired_clear", {28'd0, retired}, 32'd0);
        check("b_rom_addr_restart", {28'd0, rom_addr}, 32'd0);
        push_preload(k);
        for (int j = 0; j < 8; j++) expect_wr(k + 10 + 2 * j, b_addr[j], b_data[j]);
        wait_edge(k + 12);
        start = 1'b1;  // must be ignored mid-run
        wait_edge(k + 13);
        start = 1'b0;
        wait_edge(k + 23);
        check("b_done_early", {31'd0, done}, 32'd0);
        wait_edge(k + 24);
        check("b_done", {31'd0, done}, 32'd1);
        check("b_retired", {28'd0, retired}, 32'd8);
        check("b_rom_addr", {28'd0, rom_addr}, 32'd15);

        // Program C: program B with hold over the second EXEC
        wait_edge(k + 26);
        launch(k);
        push_preload(k);
        expect_wr(k + 10, b_addr[0], b_data[0]);
        for (int j = 1; j < 8; j++) expect_wr(k + 13 + 2 * j, b_addr[j], b_data[j]);
        wait_edge(k + 11);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_edge(k + 11 + i);
            #1;
            check("hold_we", {31'd0, rf_we}, 32'd0);
            check("hold_rom_addr", {28'd0, rom_addr}, 32'd9);
        end
        wait_edge(k + 14);
        hold = 1'b0;
        wait_edge(k + 26);
        check("c_done_early", {31'd0, done}, 32'd0);
        wait_edge(k + 27);
        check("c_done", {31'd0, done}, 32'd1);
        check("c_retired", {28'd0, retired}, 32'd8);

        // Reset in the middle of preload
        wait_edge(k + 29);
        launch(k);
        for (int i = 0; i < 3; i++) expect_wr(k + 1 + i, 3'(i), rom[i]);
        wait_edge(k + 3);
        check("pre_rst_rom_addr", {28'd0, rom_addr}, 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_rom_addr", {28'd0, rom_addr}, 32'd0);
        check("mid_rst_we", {31'd0, rf_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_wdata", {24'd0, rf_wdata}, 32'd0);
        wait_edge(k + 5);
        rst = 1'b0;

        // Program A again from IDLE after reset
        wait_edge(k + 7);
        load_rom_a();
        launch(k);
        push_preload(k);
        expect_wr(k + 10, 3'd3, 8'h01);
        wait_edge(k + 12);
        check("r_done", {31'd0, done}, 32'd1);
        check("r_retired", {28'd0, retired}, 32'd1);
        wait_edge(k + 15);
        check("queue_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
